// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pipeline_ctrl : 5-stage hazard/sequencing controller (load-use, redirect, dmem wait)
// Optional perf counters under PIPE_CTRL_PERF_EN.   Revision: 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [7:0] WAIT_MAX     = 8'd255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_Rt_i,
  input  logic [4:0] IFID_Rs_i,
  input  logic [4:0] IFID_Rt_i,
  input  logic       IFID_UsesRt_i,
  input  logic       Redirect_i,
  input  logic       Dmem_busy_i,
  output logic       PCWrite_o,
  output logic       IFID_Hold_o,
  output logic       IFID_Clear_o,
  output logic       IDEX_Bubble_o,
  output logic       Freeze_o,
  output logic       Timeout_o,
  output logic [1:0] State_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] Stall_cnt_o,
  output logic [15:0] Flush_cnt_o
`endif
);

  localparam logic [1:0] c_RUN        = 2'b00;
  localparam logic [1:0] c_BUBBLE     = 2'b01;
  localparam logic [1:0] c_FREEZE     = 2'b10;
  localparam logic [1:0] c_REDIRECT   = 2'b11;
  localparam logic [1:0] c_FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_ret_state, w_ret_nxt;
  logic [1:0] r_flush_cnt, w_flush_nxt;
  logic [1:0] w_eff_state;
  logic [7:0] r_wait_cnt, w_wait_inc;
  logic       r_timeout;
  logic       w_hazard;
  logic       w_pcwrite, w_hold, w_clear, w_bubble, w_freeze;

  assign w_hazard = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                    ((IDEX_Rt_i == IFID_Rs_i) || (IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i)));

  // Leaving FREEZE behaves exactly like the state that was frozen.
  assign w_eff_state = (r_state == c_FREEZE) ? r_ret_state : r_state;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= c_RUN;
      r_ret_state <= c_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = c_RUN;
    w_ret_nxt   = r_ret_state;
    w_flush_nxt = r_flush_cnt;
    if (Dmem_busy_i) begin
      w_state_nxt = c_FREEZE;
      if (r_state != c_FREEZE) w_ret_nxt = r_state;
    end else begin
      case (w_eff_state)
        c_REDIRECT: begin
          if (r_flush_cnt <= 2'd1) begin
            w_state_nxt = c_RUN;
            w_flush_nxt = 2'd0;
          end else begin
            w_state_nxt = c_REDIRECT;
            w_flush_nxt = r_flush_cnt - 2'd1;
          end
        end
        c_RUN, c_BUBBLE: begin
          if (Redirect_i) begin
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt = c_REDIRECT;
              w_flush_nxt = c_FLUSH_LOAD;
            end
          end else if ((w_eff_state == c_RUN) && w_hazard) begin
            w_state_nxt = c_BUBBLE;
          end
        end
        default: w_state_nxt = c_RUN;
      endcase
    end
  end

  // Output logic (before the reset override)
  always_comb begin
    w_pcwrite = 1'b1;
    w_hold    = 1'b0;
    w_clear   = 1'b0;
    w_bubble  = 1'b0;
    w_freeze  = 1'b0;
    if (Dmem_busy_i) begin
      w_pcwrite = 1'b0;
      w_hold    = 1'b1;
      w_freeze  = 1'b1;
    end else begin
      case (w_eff_state)
        c_REDIRECT: w_clear = 1'b1;
        c_RUN, c_BUBBLE: begin
          if (Redirect_i) begin
            w_clear = 1'b1;
          end else if ((w_eff_state == c_RUN) && w_hazard) begin
            w_pcwrite = 1'b0;
            w_hold    = 1'b1;
            w_bubble  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset holds the front end and freezes the back end.
  assign PCWrite_o     = rst_i ? w_pcwrite : 1'b0;
  assign IFID_Hold_o   = rst_i ? w_hold    : 1'b1;
  assign IFID_Clear_o  = rst_i ? w_clear   : 1'b0;
  assign IDEX_Bubble_o = rst_i ? w_bubble  : 1'b0;
  assign Freeze_o      = rst_i ? w_freeze  : 1'b1;
  assign State_o       = r_state;
  assign Timeout_o     = r_timeout;

  assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if (Dmem_busy_i) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc == WAIT_MAX) r_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic        w_redirect_accept;
  logic [15:0] r_stall_cnt, r_flush_evt;

  assign w_redirect_accept = !Dmem_busy_i && Redirect_i &&
                             ((w_eff_state == c_RUN) || (w_eff_state == c_BUBBLE));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 16'd0;
      r_flush_evt <= 16'd0;
    end else begin
      if (!w_pcwrite && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_redirect_accept && (r_flush_evt != 16'hFFFF)) r_flush_evt <= r_flush_evt + 16'd1;
    end
  end

  assign Stall_cnt_o = r_stall_cnt;
  assign Flush_cnt_o = r_flush_evt;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pipeline_ctrl : three instances (FLUSH 1/2/3) driven in parallel, checked against a
// cycle-level behavioural model plus directed literal expectations.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       memrd;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       uses_rt, redir, busy;
  logic [2:0] pcw, hold, clr, bub, frz, to;
  logic [1:0] st [3];

  int n_tests = 0;
  int n_fail  = 0;

  localparam int FL [3] = '{1, 2, 3};
  localparam int WM [3] = '{255, 255, 3};

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .WAIT_MAX(8'd255)) u_f1 (
    .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(memrd), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
    .Redirect_i(redir), .Dmem_busy_i(busy), .PCWrite_o(pcw[0]), .IFID_Hold_o(hold[0]),
    .IFID_Clear_o(clr[0]), .IDEX_Bubble_o(bub[0]), .Freeze_o(frz[0]),
    .Timeout_o(to[0]), .State_o(st[0]));

  pipeline_ctrl #(.FLUSH_CYCLES(2), .WAIT_MAX(8'd255)) u_f2 (
    .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(memrd), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
    .Redirect_i(redir), .Dmem_busy_i(busy), .PCWrite_o(pcw[1]), .IFID_Hold_o(hold[1]),
    .IFID_Clear_o(clr[1]), .IDEX_Bubble_o(bub[1]), .Freeze_o(frz[1]),
    .Timeout_o(to[1]), .State_o(st[1]));

  pipeline_ctrl #(.FLUSH_CYCLES(3), .WAIT_MAX(8'd3)) u_f3 (
    .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(memrd), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
    .Redirect_i(redir), .Dmem_busy_i(busy), .PCWrite_o(pcw[2]), .IFID_Hold_o(hold[2]),
    .IFID_Clear_o(clr[2]), .IDEX_Bubble_o(bub[2]), .Freeze_o(frz[2]),
    .Timeout_o(to[2]), .State_o(st[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: remaining clear cycles, whether the last non-busy cycle stalled,
  // length of the current busy run, sticky timeout, and whether last cycle was busy.
  int m_flush_left [3] = '{0, 0, 0};
  int m_busy_run   [3] = '{0, 0, 0};
  bit m_stalled    [3] = '{0, 0, 0};
  bit m_to         [3] = '{0, 0, 0};
  bit m_prev_busy  [3] = '{0, 0, 0};

  always @(negedge clk_i) begin
    logic       haz;
    logic       e_pcw, e_hold, e_clr, e_bub, e_frz, e_to;
    logic [1:0] e_st;
    haz = memrd && (idex_rt != 5'd0) &&
          ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
    for (int i = 0; i < 3; i++) begin
      e_pcw = 1'b1; e_hold = 1'b0; e_clr = 1'b0; e_bub = 1'b0; e_frz = 1'b0;
      if (!rst_i) begin
        e_pcw = 1'b0; e_hold = 1'b1; e_frz = 1'b1; e_to = 1'b0; e_st = 2'b00;
        m_flush_left[i] = 0; m_busy_run[i] = 0; m_stalled[i] = 0;
        m_to[i] = 0; m_prev_busy[i] = 0;
      end else begin
        e_to = m_to[i];
        if (m_prev_busy[i])            e_st = 2'b10;
        else if (m_flush_left[i] > 0)  e_st = 2'b11;
        else if (m_stalled[i])         e_st = 2'b01;
        else                           e_st = 2'b00;
        if (busy) begin
          e_pcw = 1'b0; e_hold = 1'b1; e_frz = 1'b1;
          if (m_busy_run[i] < 255) m_busy_run[i]++;
          if (m_busy_run[i] == WM[i]) m_to[i] = 1;
          m_prev_busy[i] = 1;
        end else begin
          m_busy_run[i] = 0;
          m_prev_busy[i] = 0;
          if (m_flush_left[i] > 0) begin
            e_clr = 1'b1;
            m_flush_left[i]--;
            m_stalled[i] = 0;
          end else if (redir) begin
            e_clr = 1'b1;
            m_flush_left[i] = FL[i] - 1;
            m_stalled[i] = 0;
          end else if (haz && !m_stalled[i]) begin
            e_pcw = 1'b0; e_hold = 1'b1; e_bub = 1'b1;
            m_stalled[i] = 1;
          end else begin
            m_stalled[i] = 0;
          end
        end
      end
      check($sformatf("model PCWrite[%0d]", i),  pcw[i],  e_pcw);
      check($sformatf("model Hold[%0d]", i),     hold[i], e_hold);
      check($sformatf("model Clear[%0d]", i),    clr[i],  e_clr);
      check($sformatf("model Bubble[%0d]", i),   bub[i],  e_bub);
      check($sformatf("model Freeze[%0d]", i),   frz[i],  e_frz);
      check($sformatf("model Timeout[%0d]", i),  to[i],   e_to);
      check($sformatf("model State[%0d]", i),    st[i],   e_st);
    end
  end

  task automatic set_in(input logic m, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] irt, input logic u, input logic r, input logic b);
    memrd = m; idex_rt = rt; ifid_rs = rs; ifid_rt = irt; uses_rt = u; redir = r; busy = b;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  initial begin
    int c0, c1, c2, fz;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 rst_i = 1'b0;

    // Reset then idle
    sample();
    check("reset PCWrite", pcw, 3'b000);
    check("reset Freeze", frz, 3'b111);
    check("reset Hold", hold, 3'b111);
    check("reset Clear", clr, 3'b000);
    next_cycle(); rst_i = 1'b1;
    sample();
    check("idle PCWrite", pcw, 3'b111);
    check("idle Freeze", frz, 3'b000);
    check("idle State", {st[2], st[1], st[0]}, 6'b000000);

    // Load-use on rs, held two cycles
    next_cycle(); set_in(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    sample();
    check("loaduse c1 Hold", hold, 3'b111);
    check("loaduse c1 Bubble", bub, 3'b111);
    check("loaduse c1 PCWrite", pcw, 3'b000);
    next_cycle();
    sample();
    check("loaduse c2 State", st[0], 2'b01);
    check("loaduse c2 Bubble", bub, 3'b000);
    check("loaduse c2 PCWrite", pcw, 3'b111);
    next_cycle(); set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    sample();
    check("rt0 no stall PCWrite", pcw, 3'b111);
    check("rt0 no stall Bubble", bub, 3'b000);

    // Load-use on rt: only when rt is actually read
    next_cycle(); set_in(1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
    sample();
    check("uses_rt stall Bubble", bub, 3'b111);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle(); set_in(1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
    sample();
    check("no uses_rt Bubble", bub, 3'b000);

    // Redirect pulse: clear count equals FLUSH_CYCLES
    next_cycle(); set_in(0, 0, 0, 0, 0, 1, 0);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0); end
      sample();
      c0 += int'(clr[0]); c1 += int'(clr[1]); c2 += int'(clr[2]);
    end
    check("flush count F1", c0, 1);
    check("flush count F2", c1, 2);
    check("flush count F3", c2, 3);
    check("after flush State F3", st[2], 2'b00);

    // Busy for 4 cycles right after the first flush cycle
    next_cycle(); set_in(0, 0, 0, 0, 0, 1, 0);
    sample();
    check("busyredir first Clear", clr, 3'b111);
    fz = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_in(0, 0, 0, 0, 0, 0, 1);
      sample();
      fz += int'(frz[1]);
    end
    check("busyredir Freeze cycles", fz, 4);
    check("busyredir frozen State", st[1], 2'b10);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
      sample();
      c0 += int'(clr[0]); c1 += int'(clr[1]); c2 += int'(clr[2]);
    end
    check("busyredir extra clears F1", c0, 0);
    check("busyredir extra clears F2", c1, 1);
    check("busyredir extra clears F3", c2, 2);

    // Timeout with WAIT_MAX=3 on instance F3
    next_cycle(); rst_i = 1'b0;
    sample();
    check("pre-timeout reset", to, 3'b000);
    next_cycle(); rst_i = 1'b1; set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) next_cycle();
      sample();
      check($sformatf("timeout busy cycle %0d", k), to[2], (k >= 4) ? 1'b1 : 1'b0);
    end
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("timeout sticky", to, 3'b100);
    next_cycle();
    sample();
    check("timeout sticky 2", to, 3'b100);
    next_cycle(); rst_i = 1'b0;
    sample();
    check("timeout cleared by reset", to, 3'b000);

    // Reset in the middle of a redirect leaves nothing pending
    next_cycle(); rst_i = 1'b1;
    next_cycle(); set_in(0, 0, 0, 0, 0, 1, 0);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("mid-redirect Clear F3", clr[2], 1'b1);
    next_cycle(); rst_i = 1'b0;
    sample();
    check("redirect abort Clear", clr, 3'b000);
    next_cycle(); rst_i = 1'b1;
    sample();
    check("after abort Clear", clr, 3'b000);
    check("after abort State F3", st[2], 2'b00);

    // Priority: busy over redirect over hazard
    next_cycle(); set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 1);
    sample();
    check("prio all Freeze", frz, 3'b111);
    check("prio all Clear", clr, 3'b000);
    check("prio all Bubble", bub, 3'b000);
    check("prio all PCWrite", pcw, 3'b000);
    next_cycle(); set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
    sample();
    check("prio nobusy Clear", clr, 3'b111);
    check("prio nobusy Bubble", bub, 3'b000);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (4) next_cycle();
    sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
